// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED sequencer: command bytes, parser states, dwell reset.
package led_seq_pkg;

  localparam logic [7:0] CmdPat   = 8'h50;  // 'P'
  localparam logic [7:0] CmdDwell = 8'h44;  // 'D'
  localparam logic [7:0] CmdGo    = 8'h47;  // 'G'
  localparam logic [7:0] CmdHalt  = 8'h48;  // 'H'
  localparam logic [7:0] CmdClr   = 8'h43;  // 'C'

  localparam logic [7:0] DwellRst = 8'hFF;

  typedef enum logic [1:0] {
    StCmd,
    StArgPat,
    StArgDwell
  } parser_e;

  function automatic logic [7:0] nibble_swap(input logic [7:0] v);
    return {v[3:0], v[7:4]};
  endfunction

endpackage

// File: rtl/led_dwell_tmr.sv
// Dwell counter: pulses expire_o once every (dwell_reg_i+1) << DWELL_SHIFT enabled cycles.
module led_dwell_tmr #(
  parameter int unsigned DWELL_SHIFT = 16
) (
  input  logic       clk_rx,
  input  logic       rst_clk_rx_n,
  input  logic       enable_i,
  input  logic       restart_i,
  input  logic [7:0] dwell_reg_i,
  output logic       expire_o
);

  localparam int unsigned TmrW = 8 + DWELL_SHIFT;

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [TmrW-1:0] limit;

  // Terminal count is period-1, i.e. {dwell, all-ones low bits}; fits in TmrW bits.
  assign limit = (TmrW'(dwell_reg_i) << DWELL_SHIFT) |
                 TmrW'((64'd1 << DWELL_SHIFT) - 64'd1);

  // Restart does not mask expiry: the caller decides which command overrides an advance.
  assign expire_o = enable_i && (tmr_q == limit);

  // Next count: held at zero while idle, cleared on restart or wrap.
  always_comb begin
    tmr_d = tmr_q + TmrW'(1);
    if (!enable_i || restart_i || expire_o) begin
      tmr_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/led_seq_ctl.sv
// LED pattern sequencer driven by a UART byte stream: loads patterns, sets dwell, runs/halts.
module led_seq_ctl
  import led_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DWELL_SHIFT = 16
) (
  input  logic       clk_rx,
  input  logic       rst_clk_rx_n,
  input  logic       btn_clk_rx,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  output logic [7:0] led_o,
  output logic       run_o,
  output logic       err_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic            rdy_q;
  parser_e         parser_q, parser_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      dwell_q, dwell_d;
  logic [7:0]      pat_q [DEPTH];
  logic [7:0]      pat_d [DEPTH];
  logic            run_q, run_d;
  logic            err_d;
  logic [7:0]      led_d;

  logic            accept;
  logic            restart;
  logic            expire;
  logic            wrap;
  logic [7:0]      display;

  assign accept = rx_data_rdy && !rdy_q;
  assign wrap   = ({1'b0, idx_q} + CntW'(1)) == count_q;

  led_dwell_tmr #(
    .DWELL_SHIFT (DWELL_SHIFT)
  ) u_dwell_tmr (
    .clk_rx       (clk_rx),
    .rst_clk_rx_n (rst_clk_rx_n),
    .enable_i     (run_q),
    .restart_i    (restart),
    .dwell_reg_i  (dwell_q),
    .expire_o     (expire)
  );

  // Parser and sequencing next state; LED value is taken from next state so a byte's
  // effect shows on led_o in the same cycle as on run_o/err_o.
  always_comb begin
    parser_d = parser_q;
    count_d  = count_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    pat_d    = pat_q;
    run_d    = run_q;
    err_d    = 1'b0;
    restart  = 1'b0;

    if (run_q && expire) begin
      idx_d = wrap ? '0 : idx_q + IdxW'(1);
    end

    if (accept) begin
      unique case (parser_q)
        StCmd: begin
          case (rx_data)
            CmdPat:   parser_d = StArgPat;
            CmdDwell: parser_d = StArgDwell;
            CmdGo: begin
              if (count_q == '0) begin
                err_d = 1'b1;
              end else begin
                run_d   = 1'b1;
                idx_d   = '0;
                restart = 1'b1;
              end
            end
            CmdHalt: begin
              run_d = 1'b0;
              idx_d = idx_q;
            end
            CmdClr: begin
              count_d = '0;
              idx_d   = '0;
              run_d   = 1'b0;
            end
            default:  err_d = 1'b1;
          endcase
        end
        StArgPat: begin
          if (count_q != DepthC) begin
            pat_d[count_q[IdxW-1:0]] = rx_data;
            count_d                  = count_q + CntW'(1);
          end else begin
            err_d = 1'b1;
          end
          parser_d = StCmd;
        end
        StArgDwell: begin
          dwell_d  = rx_data;
          restart  = 1'b1;
          parser_d = StCmd;
        end
        default: parser_d = StCmd;
      endcase
    end

    display = (count_d != '0) ? pat_d[idx_d] : 8'h00;
    led_d   = btn_clk_rx ? nibble_swap(display) : display;
  end

  // All controller state, including the registered outputs.
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      rdy_q    <= 1'b0;
      parser_q <= StCmd;
      count_q  <= '0;
      idx_q    <= '0;
      dwell_q  <= DwellRst;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= 8'h00;
      end
      run_q    <= 1'b0;
      err_o    <= 1'b0;
      led_o    <= 8'h00;
    end else begin
      rdy_q    <= rx_data_rdy;
      parser_q <= parser_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      pat_q    <= pat_d;
      run_q    <= run_d;
      err_o    <= err_d;
      led_o    <= led_d;
    end
  end

  assign run_o = run_q;

endmodule

// File: doc/led_seq_ctl.md
LED_SEQ_CTL -- requirements
Module: led_seq_ctl

Interface
REQ-001 Parameter DEPTH, default 4: pattern buffer entries, power of two, 2..16.
REQ-002 Parameter DWELL_SHIFT, default 16: dwell time scale exponent, 0..24.
REQ-003 clk_rx  input  1  sole clock; all state on posedge.
REQ-004 rst_clk_rx_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_clk_rx  input  1  nibble-swap request, already synchronous to clk_rx.
REQ-006 rx_data  input  8  received byte; valid while rx_data_rdy high.
REQ-007 rx_data_rdy  input  1  byte-ready level from the UART receiver.
REQ-008 led_o  output  8  registered LED pattern.
REQ-009 run_o  output  1  registered; high while sequencing.
REQ-010 err_o  output  1  registered one-cycle pulse on a protocol error.

Function
REQ-011 Byte acceptance: SHALL occur only on the cycle where rx_data_rdy=1 and its registered copy=0; one byte per rising edge.
REQ-012 Command bytes: 'P'=0x50 (load pattern, 1 argument), 'D'=0x44 (set dwell, 1 argument), 'G'=0x47 (go), 'H'=0x48 (halt), 'C'=0x43 (clear).
REQ-013 Parser states: CMD, ARG_PAT, ARG_DWELL; reset state CMD.
REQ-014 CMD + 'P' -> ARG_PAT; CMD + 'D' -> ARG_DWELL; any other accepted byte keeps CMD.
REQ-015 ARG_PAT + byte: if count<DEPTH, write buf[count] and count+1; if count=DEPTH, discard byte, pulse err_o, leave buffer unchanged; -> CMD.
REQ-016 ARG_DWELL + byte d: dwell_reg<=d; -> CMD; the timer restarts with the new value.
REQ-017 'G': if count=0, pulse err_o and run_o stays 0; else run_o<=1, idx<=0, timer restarts.
REQ-018 'H': run_o<=0; idx holds its value.
REQ-019 'C': count<=0, idx<=0, run_o<=0; buffer contents need not be cleared.
REQ-020 Unknown byte in CMD: pulse err_o; no other state change.
REQ-021 Dwell: while run_o=1, idx advances every (dwell_reg+1)<<DWELL_SHIFT cycles; count-1 wraps to 0.
REQ-022 Timer width: 8+DWELL_SHIFT bits; the timer is held cleared while run_o=0.
REQ-023 Display value: buf[idx] if count>0, else 8'h00.
REQ-024 led_o <= btn_clk_rx ? {display[3:0],display[7:4]} : display, updated every cycle.
REQ-025 Latency: the effect of an accepted byte SHALL appear on led_o/run_o/err_o exactly one cycle after acceptance.
REQ-026 Simultaneous dwell expiry and accepted byte: both effects apply in the same cycle; 'G', 'H', and 'C' override the idx advance.
REQ-027 A 'P' arriving while running SHALL append its entry; the new entry joins the rotation at the next wrap.

Reset
REQ-028 While rst_clk_rx_n=0: led_o=0, run_o=0, err_o=0, count=0, idx=0, dwell_reg=8'hFF, timer=0, edge register=0, parser=CMD.
REQ-029 Reset asserted mid-operation (including mid-argument) SHALL abort immediately; the first rising edge after release is treated as a command byte.

Structure
REQ-030 Package led_seq_pkg SHALL hold the command byte constants, the parser state enum, and the dwell reset value.
REQ-031 One sub-module, led_dwell_tmr, SHALL hold the dwell counter: inputs enable, restart, and dwell_reg; output expire pulse.
REQ-032 The buffer SHALL be registers (DEPTH x 8), with no RAM inference required.

Verification (DWELL_SHIFT=2 for sim)
REQ-033 'P',0xA5,'P',0x3C,'D',0x00,'G' -> led_o alternates 0xA5/0x3C every 4 cycles; run_o=1.
REQ-034 Five 'P' loads with DEPTH=4 -> err_o pulses once on the fifth argument; count=4; the rotation covers four entries.
REQ-035 'G' with an empty buffer, or unknown byte 0x7A -> single-cycle err_o; run_o=0; led_o=0x00.
REQ-036 Running, btn_clk_rx=1 showing 0xA5 -> led_o=0x5A the next cycle; 'H' freezes the value; 'C' -> led_o=0x00, run_o=0.
REQ-037 rx_data_rdy held high for 10 cycles -> exactly one byte accepted.
REQ-038 Reset pulsed between 'P' and its argument -> the following 0x47 is treated as 'G'; err_o pulses because count=0.
